ha_mod_counter: RTL
===================

Name: ha_mod_counter

Overview:
- Modulo-N synchronous up-counter whose increment datapath is a ripple chain of WIDTH `half_adder` instances; carry-in of bit 0 is `en`.
- Sits directly downstream of `half_adder` and is the first sequential consumer of it in the design.
- Provides synchronous load, a terminal-count flag, a registered wrap pulse, a sticky load-error flag, and a request/acknowledge snapshot port for reading the count.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- MODULUS, 10, count range is 0..MODULUS-1; legal range 2..2^WIDTH. Illegal values stop elaboration with a $error.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; carry-in of half-adder bit 0
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded when load=1
- count  out  WIDTH  current count, registered
- tc  out  1  combinational; 1 when count==MODULUS-1 and en=1
- wrap  out  1  registered; 1-cycle pulse in the cycle after count wraps MODULUS-1 -> 0
- load_err  out  1  sticky; set when load_val >= MODULUS is loaded
- snap_req  in  1  request to capture count
- snap_valid  out  1  snapshot data valid
- snap_data  out  WIDTH  captured count
- snap_ack  in  1  consumer acknowledge

Behaviour:
- Reset: asynchronous assertion of rst forces the following, all independent of clk:
  - count=0, wrap=0, load_err=0;
  - snap_valid=0, snap_data=0;
  - snapshot FSM enters IDLE.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-handshake drops snap_valid immediately; any pending snapshot is discarded.
- Increment datapath: the sum is built by chaining the half adders.
  - Stage i has a=count[i] and b=carry[i-1]; carry[-1]=en.
  - The final carry-out is unused.
  - Sum width is WIDTH bits.
- Count update priority, evaluated per clk edge:
  1. load=1 and load_val<MODULUS: count<=load_val.
  2. load=1 and load_val>=MODULUS: count<=0 and load_err<=1. load_err clears only on rst.
  3. en=1 and count==MODULUS-1: count<=0 and wrap<=1.
  4. en=1 otherwise: count<=half-adder sum (count+1).
  5. en=0: count holds.
- wrap:
  - Is 0 in every cycle not covered by rule 3.
  - load has priority over a pending wrap: with load=1 and en=1 at count==MODULUS-1, the value is loaded and wrap stays 0.
- When MODULUS==2^WIDTH, the wrap occurs naturally through the half-adder overflow; the compare logic must still produce wrap=1 at that point.
- tc is purely combinational from count and en and may glitch. It is asserted even when load=1 in the same cycle.
- Snapshot FSM, states IDLE and HOLD:
  - IDLE, snap_req=1: snap_data<=count (pre-update value of this edge), snap_valid<=1, go to HOLD. Latency from req to valid is 1 cycle.
  - IDLE, snap_req=0: stay in IDLE with snap_valid=0.
  - HOLD: snap_data and snap_valid are held stable. snap_req is ignored.
  - HOLD, snap_ack=1: snap_valid<=0, return to IDLE. A snap_req in the same cycle is not accepted; the requester re-asserts.
  - snap_ack in IDLE is ignored.
  - The counter runs independently of the FSM; the snapshot never stalls counting.
- No combinational path from any input to snap_valid or snap_data.

Test Plan:
- Reset and count, WIDTH=4, MODULUS=10: assert rst mid-cycle, release it, then hold en=1 for 12 cycles. Required: count 0,1..9,0,1; wrap=1 only in the cycle after 9->0; tc=1 only while count=9.
- Enable gating: en toggles 1,0,0,1 starting at count=3. Required: count 4,4,4,5; no wrap; tc never asserted.
- Load priority and error:
  - Load 7 while en=1: count=7 next cycle.
  - Load 12: count=0 and load_err=1, which persists across 5 further cycles and clears only after rst.
  - Load 2 at count=9 with en=1: count=2, wrap stays 0.
- Full-range modulus, WIDTH=3, MODULUS=8: 9 cycles with en=1. Required: 0..7 then 0; wrap pulses once after 7->0.
- Snapshot handshake:
  - snap_req at count=5: snap_valid=1 and snap_data=5 next cycle.
  - Hold snap_ack=0 for 3 cycles while the counter advances to 8: snap_data stays 5.
  - snap_ack=1 with snap_req=1 in the same cycle: snap_valid=0 next cycle, and no new capture until snap_req is re-asserted.
- Reset mid-operation: assert rst asynchronously while in HOLD at count=6. Required: snap_valid, count, wrap and load_err all read 0 before the next clk edge; FSM is in IDLE after release.

Source files
------------

// File: rtl/ha_mod_counter.sv
// Modulo-N up-counter built on a ripple chain of half adders, with synchronous
// load, terminal-count/wrap flags, sticky load error and a snapshot handshake.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module ha_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err,
    input  logic             snap_req,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_data,
    input  logic             snap_ack
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("ha_mod_counter: WIDTH must be in 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("ha_mod_counter: MODULUS must be in 2..2^WIDTH");
    end

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    typedef enum logic {IDLE, HOLD} snap_state_t;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             carry_unused;
    logic             at_last;
    logic             load_ok;
    logic             capture;
    snap_state_t      state;
    snap_state_t      state_next;

    // Stage i adds count[i] and the carry from stage i-1; en is the first carry-in.
    assign carry[0] = en;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        half_adder u_ha (
            .a     (count[i]),
            .b     (carry[i]),
            .sum   (sum[i]),
            .carry (carry[i+1])
        );
    end
    assign carry_unused = carry[WIDTH];

    assign at_last = (count == LAST);
    assign load_ok = ({1'b0, load_val} < MOD_EXT);
    assign tc      = en & at_last;

    // Explicit compare at LAST keeps wrap correct even when the sum overflows naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count <= load_val;
                end else begin
                    count    <= '0;
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (at_last) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= sum;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (snap_req) state_next = HOLD;
            HOLD:    if (snap_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // snap_valid decodes registered state only, so no input reaches it combinationally.
    always_comb begin
        snap_valid = (state == HOLD);
        capture    = (state == IDLE) && snap_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data <= '0;
        end else if (capture) begin
            snap_data <= count;
        end
    end

endmodule
